seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
Multi-cycle, parametrised successor to the 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands by rippling through CHUNK-bit slices, one slice per clock, with a registered carry between slices. The block has valid/ready handshakes on input and output, so it drops into streaming datapaths where a full-width combinational ripple would miss timing.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived localparam; number of CALC cycles per operation

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand request
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add mode only)
op_sub  in  1  0 = A+B+cin; 1 = A-B (cin ignored)
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB; in subtract mode 1 = no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset, asynchronous while rst=1: state=IDLE. sum, cout, ovf, out_valid and internal carry/index registers are all 0. in_ready=1 once rst deasserts. Any in-flight operation is discarded; no result is emitted for it.
- FSM states are IDLE, CALC and DONE.
- in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE), registered.
- IDLE: on in_valid&&in_ready at a rising edge:
  - Capture a into opA.
  - Capture b, or ~b when op_sub, into opB.
  - Load carry = op_sub ? 1 : cin.
  - Set idx=0 and go to CALC.
  - Inputs are ignored after capture.
- CALC: each cycle, slice idx is added: {c, s} = opA[idx] + opB[idx] + carry.
  - sum[idx*CHUNK +: CHUNK] <= s.
  - carry <= c.
  - idx <= idx+1.
- On the final slice (idx==NCHUNK-1):
  - cout <= c.
  - ovf <= (opA[MSB]==opB[MSB]) && (s[MSB]!=opA[MSB]).
  - Go to DONE.
- Latency: out_valid rises exactly NCHUNK clocks after the accepting edge. For NCHUNK=1 the block is a single CALC cycle.
- DONE: sum, cout and ovf stay stable while out_ready=0, for unlimited backpressure. On out_ready=1 the state goes to IDLE at that edge.
- out_ready is allowed to be high before or at the cycle out_valid rises; the transfer occurs on the first edge where both are 1.
- No overlap: throughput is one operation per NCHUNK+2 cycles minimum (accept, NCHUNK calc, handoff).
- sum holds partial slices during CALC. Downstream qualifies sum with out_valid. sum, cout and ovf are not cleared on leaving DONE.
- Arithmetic is modulo 2^WIDTH, with no saturation.

Decomposition:
- Shared package adder_pkg holds:
  - the state enum type (IDLE/CALC/DONE);
  - the OP_ADD/OP_SUB constants;
  - a compile-time check function for WIDTH%CHUNK==0.
- One sub-module, rca_chunk (parameter N=CHUNK): the combinational N-bit ripple-carry adder. Ports are a, b, cin, sum, cout, built from full-adder cells. seq_chunk_adder instantiates it once and reuses it each cycle via slice muxing.

Test Plan:
1. Reset: hold rst=1 for 3 cycles, including mid-CALC of a pending op -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 after release, and no stale result ever appears.
2. Basic add (WIDTH=16, CHUNK=4): a=0x0001, b=0x0002, cin=1 -> sum=0x0004, cout=0, ovf=0; out_valid asserts exactly 4 cycles after acceptance.
3. Cross-chunk ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x0FFF, b=0x0001 -> sum=0x1000, cout=0.
4. Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0xFFFF -> sum=0x7FFF, cout=1, ovf=1.
5. Subtract: a=0x0005, b=0x0003, op_sub=1, cin=1 (ignored) -> sum=0x0002, cout=1, ovf=0. Also a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0.
6. Backpressure: hold out_ready=0 for 6 cycles after out_valid -> result stable, in_ready=0, new in_valid not accepted. Release out_ready -> IDLE next edge, and back-to-back ops complete in order. Repeat all cases with CHUNK=1 and CHUNK=16.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked sequential adder.
// Contents: FSM state type, operation-select constants and a
// compile-time parameter legality check.
package adder_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding of the op_sub input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // True when CHUNK evenly tiles WIDTH and lies in 1..WIDTH
    function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
        if (chunk == 0 || chunk > width) begin
            return 1'b0;
        end
        return (width % chunk) == 0;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
// Ports: a, b (N-bit operands), cin (carry in), sum (N-bit result),
//        cout (carry out of bit N-1).
module rca_chunk #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: ripples a WIDTH-bit operation through
// one CHUNK-bit slice per clock with a registered inter-slice carry.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, op_sub)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   cout                carry out of MSB (subtract: 1 = no borrow)
//   ovf                 two's-complement signed overflow
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Reject illegal WIDTH/CHUNK combinations at elaboration
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_error
        $error("seq_chunk_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
    end

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [31:0]      base;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;

    assign in_ready = (state == IDLE);

    // Select the active slice; the single adder is reused every CALC cycle
    assign base    = 32'(idx) * 32'(CHUNK);
    assign slice_a = opa[base +: CHUNK];
    assign slice_b = opb[base +: CHUNK];

    rca_chunk #(
        .N(CHUNK)
    ) u_rca (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry),
        .sum (slice_s),
        .cout(slice_c)
    );

    // Sequencer, operand capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        // Subtract as A + ~B + 1
                        opb   <= (op_sub == OP_SUB) ? ~b : b;
                        carry <= (op_sub == OP_SUB) ? 1'b1 : cin;
                        idx   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    sum[base +: CHUNK] <= slice_s;
                    carry              <= slice_c;
                    idx                <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= slice_c;
                        // Overflow: like-signed operands, result sign differs
                        ovf       <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                     (slice_s[CHUNK-1] != opa[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: three adders (CHUNK = 4, 16, 1) share one stimulus
// stream and are compared against an arithmetic reference model.
module tb_seq_chunk_adder;

    localparam int W = 16;
    localparam int NCH [3] = '{4, 1, 16};   // CHUNK=4, CHUNK=16, CHUNK=1

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_ready;

    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   cout_v;
    logic [2:0]   ovf_v;
    logic [W-1:0] sum_v [3];

    int vectors = 0;
    int miscompares = 0;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int sa, sb, sv;
        int unsigned u;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            es = ma - mb;
            ec = (ma >= mb);
            sv = sa - sb;
        end else begin
            u  = int'(ma) + int'(mb) + int'(mcin);
            es = u[W-1:0];
            ec = (u > 32'd65535);
            sv = sa + sb + int'(mcin);
        end
        eo = (sv > 32767) || (sv < -32768);
    endtask

    // Issue one operation; optionally hold out_ready low for 6 cycles once all are valid
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input bit hold);
        logic [W-1:0] es;
        logic ec, eo;
        logic [2:0] seen;
        int cyc;
        int n;
        model(ta, tb, tcin, tsub, es, ec, eo);

        n = 0;
        @(negedge clk);
        while (!(&in_ready_v) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(&in_ready_v)) check_eq({tag, " idle timeout"}, 32'(in_ready_v), 32'h7);

        out_ready = hold ? 1'b0 : 1'b1;
        a = ta; b = tb; cin = tcin; op_sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check_eq({tag, " in_ready after accept"}, 32'(in_ready_v), 32'h0);

        seen = 3'b000;
        cyc = 0;
        while (seen != 3'b111 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (out_valid_v[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    check_eq($sformatf("%s c%0d latency", tag, NCH[i]), 32'(cyc), 32'(NCH[i] == 1 ? 1 : (NCH[i] == 4 ? 4 : 16)));
                    check_eq($sformatf("%s c%0d sum", tag, NCH[i]), 32'(sum_v[i]), 32'(es));
                    check_eq($sformatf("%s c%0d cout", tag, NCH[i]), 32'(cout_v[i]), 32'(ec));
                    check_eq($sformatf("%s c%0d ovf", tag, NCH[i]), 32'(ovf_v[i]), 32'(eo));
                end
            end
        end
        if (seen != 3'b111) check_eq({tag, " result timeout"}, 32'(seen), 32'h7);

        if (hold) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
                @(posedge clk);
                #1;
                check_eq($sformatf("%s hold%0d out_valid", tag, k), 32'(out_valid_v), 32'h7);
                check_eq($sformatf("%s hold%0d in_ready", tag, k), 32'(in_ready_v), 32'h0);
                for (int i = 0; i < 3; i++)
                    check_eq($sformatf("%s hold%0d c%0d sum", tag, k, NCH[i]), 32'(sum_v[i]), 32'(es));
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check_eq({tag, " release out_valid"}, 32'(out_valid_v), 32'h0);
            check_eq({tag, " release in_ready"}, 32'(in_ready_v), 32'h7);
        end
    endtask

    // Assert reset mid-operation; no result may appear afterwards
    task automatic reset_mid_op();
        bit stale;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst out_valid", 32'(out_valid_v), 32'h0);
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("midrst c%0d sum", NCH[i]), 32'(sum_v[i]), 32'h0);
            check_eq($sformatf("midrst c%0d cout/ovf", NCH[i]), 32'({cout_v[i], ovf_v[i]}), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst in_ready", 32'(in_ready_v), 32'h7);
        stale = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_v != 3'b000) stale = 1'b1;
        end
        check_eq("midrst stale result", 32'(stale), 32'h0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset out_valid", 32'(out_valid_v), 32'h0);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("reset c%0d sum/cout/ovf", NCH[i]), {15'd0, cout_v[i], sum_v[i]} | {31'd0, ovf_v[i]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset in_ready", 32'(in_ready_v), 32'h7);

        run_op("basic",      16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("ripple_mid", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("ovf_neg",    16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_pos",    16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
        run_op("sub_neg",    16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0);
        run_op("sub_min",    16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("backpress",  16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b1);
        run_op("after_bp",   16'hABCD, 16'h1111, 1'b0, 1'b1, 1'b0);

        reset_mid_op();

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0001;
            run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
